// File: rtl/probe_burst_generator_pkg.sv
// rtl/probe_burst_generator_pkg.sv - state encoding and default burst parameters
package probe_burst_generator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_BURST = 2'd2,
        ST_GUARD = 2'd3
    } state_t;

    localparam int                 DEF_BURST_LEN   = 8;
    localparam int                 DEF_HALF_PERIOD = 2;
    localparam logic signed [15:0] DEF_AMPLITUDE   = 16'sd16384;
    localparam int                 DEF_GUARD_LEN   = 4;

endpackage

// File: rtl/probe_burst_generator.sv
// rtl/probe_burst_generator.sv - square-wave probe burst with guard interval, paced by audio sample strobes
module probe_burst_generator
    import probe_burst_generator_pkg::*;
#(
    parameter int                 BURST_LEN   = DEF_BURST_LEN,
    parameter int                 HALF_PERIOD = DEF_HALF_PERIOD,
    parameter logic signed [15:0] AMPLITUDE   = DEF_AMPLITUDE,
    parameter int                 GUARD_LEN   = DEF_GUARD_LEN
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               step_in,
    input  logic               trigger_in,
    input  logic               abort_in,
    output logic signed [15:0] amp_out,
    output logic               burst_start_out,
    output logic               busy_out,
    output logic               done_out
);

    localparam int              CNT_MAX = (BURST_LEN > GUARD_LEN) ? BURST_LEN : GUARD_LEN;
    localparam int              CW      = $clog2(CNT_MAX) + 1;
    localparam logic [CW-1:0]   K_LAST  = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0]   G_LAST  = CW'(GUARD_LEN - 1);

    state_t             r_state, w_state;
    logic [CW-1:0]      r_k, w_k;
    logic [CW-1:0]      r_g, w_g;
    logic signed [15:0] r_amp, w_amp;
    logic               r_start, w_start;
    logic               r_done, w_done;
    logic               r_busy, w_busy;

    // End samples are halved to soften the speaker transient at burst edges.
    function automatic logic signed [15:0] sample_value(input logic [CW-1:0] k);
        int                 idx;
        logic signed [15:0] mag;
        idx = int'(k);
        mag = (idx == 0 || idx == BURST_LEN - 1) ? (AMPLITUDE >>> 1) : AMPLITUDE;
        return (((idx / HALF_PERIOD) % 2) == 0) ? mag : -mag;
    endfunction

    always_comb begin
        w_state = r_state;
        w_k     = r_k;
        w_g     = r_g;
        w_amp   = r_amp;
        w_start = 1'b0;
        w_done  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_amp = '0;
                if (trigger_in && !abort_in) begin
                    w_state = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (step_in) begin
                    w_state = ST_BURST;
                    w_k     = '0;
                    w_amp   = sample_value('0);
                    w_start = 1'b1;
                end
            end
            ST_BURST: begin
                if (step_in) begin
                    if (r_k == K_LAST) begin
                        w_state = ST_GUARD;
                        w_k     = '0;
                        w_g     = '0;
                        w_amp   = '0;
                    end else begin
                        w_k   = r_k + CW'(1);
                        w_amp = sample_value(r_k + CW'(1));
                    end
                end
            end
            ST_GUARD: begin
                if (step_in) begin
                    if (r_g == G_LAST) begin
                        w_state = ST_IDLE;
                        w_g     = '0;
                        w_done  = 1'b1;
                    end else begin
                        w_g = r_g + CW'(1);
                    end
                end
            end
            default: begin
                w_state = ST_IDLE;
                w_k     = '0;
                w_g     = '0;
                w_amp   = '0;
            end
        endcase

        // Abort overrides any step or trigger seen in the same cycle.
        if (abort_in && r_state != ST_IDLE) begin
            w_state = ST_IDLE;
            w_k     = '0;
            w_g     = '0;
            w_amp   = '0;
            w_start = 1'b0;
            w_done  = 1'b0;
        end

        w_busy = (w_state != ST_IDLE);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state <= ST_IDLE;
            r_k     <= '0;
            r_g     <= '0;
            r_amp   <= '0;
            r_start <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_k     <= w_k;
            r_g     <= w_g;
            r_amp   <= w_amp;
            r_start <= w_start;
            r_done  <= w_done;
            r_busy  <= w_busy;
        end
    end

    assign amp_out         = r_amp;
    assign burst_start_out = r_start;
    assign busy_out        = r_busy;
    assign done_out        = r_done;

endmodule

// File: tb/tb_probe_burst_generator.sv
// tb/tb_probe_burst_generator.sv - directed self-checking bench for probe_burst_generator
module tb_probe_burst_generator;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               step = 1'b0, trig = 1'b0, abort = 1'b0;
    logic               step2 = 1'b0, trig2 = 1'b0;
    logic signed [15:0] amp, amp2;
    logic               bstart, busy, done;
    logic               bstart2, busy2, done2;

    int n_checks = 0;
    int n_fail   = 0;
    int n_start  = 0;
    int n_done   = 0;

    int s_amp, s_start, s_done, s_busy, s_busy2;
    int s_amp2, s_start2, s_done2;

    int exp_def[9] = '{8192, 16384, -16384, -16384, 16384, 16384, -16384, -8192, 0};
    int exp_hp1[5] = '{8192, -16384, 16384, -8192, 0};

    always #5 clk = ~clk;

    probe_burst_generator dut (
        .clk_in(clk), .rst_in(rst_n), .step_in(step), .trigger_in(trig), .abort_in(abort),
        .amp_out(amp), .burst_start_out(bstart), .busy_out(busy), .done_out(done)
    );

    probe_burst_generator #(.BURST_LEN(4), .HALF_PERIOD(1), .GUARD_LEN(4)) dut2 (
        .clk_in(clk), .rst_in(rst_n), .step_in(step2), .trigger_in(trig2), .abort_in(1'b0),
        .amp_out(amp2), .burst_start_out(bstart2), .busy_out(busy2), .done_out(done2)
    );

    always @(negedge clk) begin
        if (bstart) n_start++;
        if (done)   n_done++;
    end

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One step strobe to both instances, then sample, then idle to a 10-clk pace.
    task automatic strobe();
        @(negedge clk); step = 1'b1; step2 = 1'b1;
        @(negedge clk); step = 1'b0; step2 = 1'b0;
        s_amp  = amp;  s_start  = bstart;  s_done  = done;  s_busy = busy;
        s_amp2 = amp2; s_start2 = bstart2; s_done2 = done2;
        @(negedge clk); s_busy2 = busy;
        repeat (7) @(negedge clk);
    endtask

    task automatic fire();
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
    endtask

    task automatic pulse_trig();
        @(negedge clk); trig = 1'b1;
        @(negedge clk); trig = 1'b0;
    endtask

    // Full default burst + guard; dut must already be armed (or about to arm).
    task automatic check_burst(input string tag, input bit poke_trig, input int exp_rearm);
        for (int i = 0; i < 9; i++) begin
            strobe();
            check_eq($sformatf("%s_amp%0d", tag, i), s_amp, exp_def[i]);
            check_eq($sformatf("%s_start%0d", tag, i), s_start, (i == 0) ? 1 : 0);
            if (poke_trig) pulse_trig();
        end
        for (int g = 1; g <= 4; g++) begin
            strobe();
            check_eq($sformatf("%s_guard_amp%0d", tag, g), s_amp, 0);
            check_eq($sformatf("%s_done%0d", tag, g), s_done, (g == 4) ? 1 : 0);
            if (poke_trig && g < 4) pulse_trig();
        end
        check_eq({tag, "_busy_at_done"}, s_busy, 0);
        check_eq({tag, "_busy_after_done"}, s_busy2, exp_rearm);
    endtask

    initial begin
        int base_s, base_d;

        // Reset state
        repeat (2) @(negedge clk);
        check_eq("rst_amp", amp, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_start", bstart, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_amp2", amp2, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Default burst from a trigger pulse
        base_s = n_start; base_d = n_done;
        fire();
        check_eq("arm_busy", busy, 1);
        check_eq("arm_amp", amp, 0);
        check_burst("basic", 1'b0, 0);
        check_eq("basic_n_start", n_start - base_s, 1);
        check_eq("basic_n_done", n_done - base_d, 1);

        // Triggers during BURST and GUARD are ignored
        base_s = n_start; base_d = n_done;
        fire();
        check_burst("ign", 1'b1, 0);
        repeat (20) @(negedge clk);
        check_eq("ign_n_start", n_start - base_s, 1);
        check_eq("ign_n_done", n_done - base_d, 1);
        check_eq("ign_idle_busy", busy, 0);

        // Abort at k=3, with a coincident step
        base_s = n_start; base_d = n_done;
        fire();
        for (int i = 0; i < 4; i++) strobe();
        check_eq("abort_pre_amp", s_amp, -16384);
        @(negedge clk); abort = 1'b1; step = 1'b1;
        @(negedge clk); abort = 1'b0; step = 1'b0;
        check_eq("abort_amp", amp, 0);
        check_eq("abort_busy", busy, 0);
        check_eq("abort_start", bstart, 0);
        for (int i = 0; i < 6; i++) strobe();
        check_eq("abort_idle_amp", s_amp, 0);
        check_eq("abort_n_done", n_done - base_d, 0);
        check_eq("abort_n_start", n_start - base_s, 1);

        // Abort and trigger together in IDLE: stay idle
        @(negedge clk); abort = 1'b1; trig = 1'b1;
        @(negedge clk); abort = 1'b0; trig = 1'b0;
        check_eq("abort_trig_busy", busy, 0);
        @(negedge clk);
        check_eq("abort_trig_busy2", busy, 0);

        base_d = n_done;
        fire();
        check_burst("post_abort", 1'b0, 0);
        check_eq("post_abort_n_done", n_done - base_d, 1);

        // Asynchronous reset at k=5
        base_s = n_start; base_d = n_done;
        fire();
        for (int i = 0; i < 6; i++) strobe();
        check_eq("rstmid_pre_amp", s_amp, 16384);
        @(posedge clk); #2; rst_n = 1'b0; #1;
        check_eq("rstmid_amp", amp, 0);
        check_eq("rstmid_busy", busy, 0);
        @(negedge clk); rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            strobe();
            check_eq($sformatf("rstmid_idle_amp%0d", i), s_amp, 0);
            check_eq($sformatf("rstmid_idle_busy%0d", i), s_busy, 0);
        end
        check_eq("rstmid_n_start", n_start - base_s, 1);
        check_eq("rstmid_n_done", n_done - base_d, 0);

        // Trigger held high: back-to-back cycles, one idle clk between
        @(negedge clk); trig = 1'b1;
        @(negedge clk);
        check_burst("held1", 1'b0, 1);
        check_eq("held_gap_armed", s_busy2, 1);
        for (int i = 0; i < 9; i++) begin
            strobe();
            check_eq($sformatf("held2_amp%0d", i), s_amp, exp_def[i]);
            if (i == 0) check_eq("held2_start", s_start, 1);
        end
        trig = 1'b0;
        for (int g = 1; g <= 4; g++) strobe();
        check_eq("held2_done", s_done, 1);
        check_eq("held2_idle", s_busy2, 0);

        // HALF_PERIOD=1, BURST_LEN=4 instance
        @(negedge clk); trig2 = 1'b1;
        @(negedge clk); trig2 = 1'b0;
        check_eq("hp1_busy", busy2, 1);
        for (int i = 0; i < 5; i++) begin
            strobe();
            check_eq($sformatf("hp1_amp%0d", i), s_amp2, exp_hp1[i]);
            check_eq($sformatf("hp1_start%0d", i), s_start2, (i == 0) ? 1 : 0);
        end
        for (int g = 1; g <= 4; g++) begin
            strobe();
            check_eq($sformatf("hp1_done%0d", g), s_done2, (g == 4) ? 1 : 0);
        end
        check_eq("hp1_idle_busy", busy2, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
